shift_arbiter: RTL
==================

Name: shift_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one registered 32-bit variable shifter (1-cycle latency, enable-gated, holds q when enable low) between NREQ requesters.
- Accepts one request at a time via valid/ready, drives the shifter's enable/direction/amount/data for exactly one cycle, and captures the result.
- Returns the result on a single response channel tagged with the requester index.
- Sits between the requesting datapath units and the shifter instance.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 32, data width; must equal shifter width.
- SHW, 6, shift-amount width.
- IDW, 3, response-ID width; requires 2**IDW >= NREQ.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_dir  in  NREQ  per-requester direction; 0 = right, 1 = left.
- req_shift  in  NREQ*SHW  packed amounts; requester i at [i*SHW +: SHW].
- req_data  in  NREQ*WIDTH  packed operands; requester i at [i*WIDTH +: WIDTH].
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  index of the requester that owns the result.
- resp_data  out  WIDTH  shifted result.
- busy  out  1  high in any state other than IDLE.
- sh_en  out  1  shifter enable.
- sh_dir  out  1  shifter direction.
- sh_shift  out  SHW  shifter amount.
- sh_in  out  WIDTH  shifter operand.
- sh_q  in  WIDTH  shifter output, registered, valid the cycle after sh_en.

Behaviour:
- Reset (clr=1 at posedge) forces:
  - state = IDLE, rr_ptr = 0.
  - req_ready = 0, resp_valid = 0, resp_id = 0, resp_data = 0, busy = 0.
  - sh_en = 0, sh_dir = 0, sh_shift = 0, sh_in = 0.
  - Reset mid-operation abandons the op; no response is ever produced for it.
- Arbitration (combinational, IDLE only):
  - Grant the first requester with req_valid=1, searching from rr_ptr upward with wrap modulo NREQ.
  - req_ready[grant] = 1; all other bits 0. req_ready = 0 in every state except IDLE.
  - req_ready must not depend on anything except state, rr_ptr and req_valid.
- Handshake:
  - A transfer occurs at the posedge where req_valid[i] & req_ready[i].
  - Latch dir, shift, data and id = i; set rr_ptr = (i+1) mod NREQ.
  - Unaccepted requesters keep valid asserted; the block imposes no ordering beyond round-robin.
- State machine:
  - IDLE: on transfer with latched shift < WIDTH -> ISSUE; with shift >= WIDTH -> RESP, result = 0, shifter bypassed.
  - ISSUE (1 cycle): sh_en = 1; sh_dir, sh_shift, sh_in = latched values -> EXEC.
  - EXEC (1 cycle): sh_en = 0; resp_data <= sh_q -> RESP.
  - RESP: resp_valid = 1; resp_id and resp_data held stable until resp_ready. On resp_valid & resp_ready -> IDLE.
- sh_en is high only in ISSUE. sh_dir, sh_shift and sh_in hold their last values otherwise.
- Latency from accept edge T:
  - Normal path: resp_valid rises after edge T+2 (visible in cycle 3).
  - Bypass path (shift >= WIDTH): resp_valid visible in cycle 1.
- Throughput: at most one op outstanding. A new accept can occur the cycle after the response handshake, since IDLE is re-entered at that edge.
- Shift of 0 goes through the shifter; the expected result equals the operand.
- resp_ready held high in RESP: single-cycle response, then IDLE.
- resp_ready asserted outside RESP is ignored.
- req_valid deasserting while not granted: no effect, no error.

Test Plan:
- Single op: req0 valid, dir=1, shift=4, data=0x0000_00F1 -> sh_en pulses 1 cycle with those operands; resp_valid 3 cycles after accept, resp_id=0, resp_data=0x0000_0F10.
- Round robin: req0 and req1 both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1; rr_ptr wraps. Four responses carry ids 0,1,0,1 and correct data (req1: dir=0, shift=8, 0xAB00_0000 -> 0x00AB_0000).
- Bypass: shift=40, data=0xFFFF_FFFF -> no sh_en pulse; resp_data=0, resp_valid the cycle after accept.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_id, resp_data stable; req_ready=0 throughout; the next grant is issued only after the handshake.
- Reset mid-op: assert clr during EXEC -> next cycle all outputs at reset values; rr_ptr=0; no response ever appears for the aborted op; the subsequent op on req1 completes normally.
- Shift zero: dir=0, shift=0, data=0x1234_5678 -> resp_data=0x1234_5678 via the normal 3-cycle path.

Source files
------------

// File: rtl/shift_arbiter.sv
// Round-robin arbiter that serialises NREQ requesters onto one shared
// registered shifter and returns each result tagged with its requester id.
module shift_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32,
    parameter int SHW   = 6,
    parameter int IDW   = 3
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_dir,
    input  logic [NREQ*SHW-1:0]   req_shift,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  busy,
    output logic                  sh_en,
    output logic                  sh_dir,
    output logic [SHW-1:0]        sh_shift,
    output logic [WIDTH-1:0]      sh_in,
    input  logic [WIDTH-1:0]      sh_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_r, state_nx_s;
    logic [IDW-1:0]   rr_ptr_r;
    logic [IDW-1:0]   resp_id_r;
    logic [WIDTH-1:0] resp_data_r;
    logic             sh_dir_r;
    logic [SHW-1:0]   sh_shift_r;
    logic [WIDTH-1:0] sh_in_r;

    logic             found_s;
    logic [IDW-1:0]   grant_idx_s;
    logic [IDW-1:0]   grant_nxt_s;
    int               dist_s;
    int               best_s;
    logic             sel_dir_s;
    logic [SHW-1:0]   sel_shift_s;
    logic [WIDTH-1:0] sel_data_s;
    logic             accept_s;
    logic             bypass_s;

    // Round-robin search: the valid requester closest above rr_ptr (with wrap) wins.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = '0;
        grant_nxt_s = '0;
        dist_s      = 0;
        best_s      = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            dist_s = (i >= int'(rr_ptr_r)) ? (i - int'(rr_ptr_r))
                                            : (i + NREQ - int'(rr_ptr_r));
            if (req_valid[i] && (dist_s < best_s)) begin
                best_s      = dist_s;
                found_s     = 1'b1;
                grant_idx_s = IDW'(i);
                grant_nxt_s = IDW'((i + 1) % NREQ);
            end else begin
                best_s      = best_s;
            end
        end
    end

    // Grant decode: only state, rr_ptr and req_valid feed req_ready.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (state_r == IDLE) && found_s && (grant_idx_s == IDW'(i));
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_dir_s   = 1'b0;
        sel_shift_s = '0;
        sel_data_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx_s == IDW'(i)) begin
                sel_dir_s   = req_dir[i];
                sel_shift_s = req_shift[i*SHW +: SHW];
                sel_data_s  = req_data[i*WIDTH +: WIDTH];
            end else begin
                sel_dir_s   = sel_dir_s;
            end
        end
    end

    assign accept_s = |req_ready;
    // Amounts of WIDTH or more clear every bit, so the shifter is skipped.
    assign bypass_s = (int'(sel_shift_s) >= WIDTH);

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = bypass_s ? RESP : ISSUE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE:   state_nx_s = EXEC;
            EXEC:    state_nx_s = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Datapath registers: pointer, tag, shifter operands and captured result.
    always_ff @(posedge clk) begin
        if (clr) begin
            rr_ptr_r    <= '0;
            resp_id_r   <= '0;
            resp_data_r <= '0;
            sh_dir_r    <= 1'b0;
            sh_shift_r  <= '0;
            sh_in_r     <= '0;
        end else begin
            if (accept_s) begin
                rr_ptr_r  <= grant_nxt_s;
                resp_id_r <= grant_idx_s;
                if (!bypass_s) begin
                    sh_dir_r   <= sel_dir_s;
                    sh_shift_r <= sel_shift_s;
                    sh_in_r    <= sel_data_s;
                end else begin
                    resp_data_r <= '0;
                end
            end else if (state_r == EXEC) begin
                resp_data_r <= sh_q;
            end else begin
                resp_data_r <= resp_data_r;
            end
        end
    end

    assign busy       = (state_r != IDLE);
    assign resp_valid = (state_r == RESP);
    assign sh_en      = (state_r == ISSUE);
    assign resp_id    = resp_id_r;
    assign resp_data  = resp_data_r;
    assign sh_dir     = sh_dir_r;
    assign sh_shift   = sh_shift_r;
    assign sh_in      = sh_in_r;

endmodule
